// File: rtl/fir_xifu_regfile_sb.sv
// FIR XIFU packed-tap register file with per-register scoreboard, owner IDs, commit-kill and sample shift-in.
// Optional WB-to-ID bypass is enabled by defining FIR_XIFU_FWD_EN.
module fir_xifu_regfile_sb #(
    parameter int NB_REGS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NB_RPORTS  = 2,
    parameter int ID_WIDTH   = 4,
    localparam int RW        = (NB_REGS > 1) ? $clog2(NB_REGS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    id_valid_i,
    input  logic [NB_RPORTS*RW-1:0] id_rs_i,
    input  logic [NB_RPORTS-1:0]    id_rs_use_i,
    input  logic [RW-1:0]           id_rd_i,
    input  logic                    id_rd_we_i,
    input  logic [ID_WIDTH-1:0]     id_id_i,
    output logic                    id_ready_o,
    output logic [NB_RPORTS*32-1:0] id_rdata_o,
    input  logic                    wb_valid_i,
    input  logic [RW-1:0]           wb_rd_i,
    input  logic [ID_WIDTH-1:0]     wb_id_i,
    input  logic [1:0]              wb_mode_i,
    input  logic [31:0]             wb_wdata_i,
    input  logic                    kill_valid_i,
    input  logic [ID_WIDTH-1:0]     kill_id_i,
    output logic [NB_REGS-1:0]      sb_o,
    output logic                    busy_o,
    output logic                    wb_err_o
);

    localparam logic [31:0] TAP_MASK = 32'((64'd1 << DATA_WIDTH) - 64'd1);

    logic [NB_REGS-1:0][31:0]       regs_q, regs_d;
    logic [NB_REGS-1:0]             sb_q, sb_d;
    logic [NB_REGS-1:0][ID_WIDTH-1:0] owner_q, owner_d;
    logic                           wb_err_q, wb_err_d;

    logic [NB_REGS-1:0]             kill_hit;
    logic [NB_REGS-1:0]             pend;
    logic                           wb_acc;
    logic                           wb_eff;
    logic [31:0]                    wb_new;
    logic                           ready;
    logic                           issue_acc;
    logic [NB_RPORTS-1:0][RW-1:0]   rs_idx;

    // WB acceptance, kill matching and the post-mode value of the WB target
    always_comb begin
        wb_acc = wb_valid_i && sb_q[wb_rd_i] && (owner_q[wb_rd_i] == wb_id_i);
        for (int r = 0; r < NB_REGS; r++) begin
            kill_hit[r] = kill_valid_i && sb_q[r] && (owner_q[r] == kill_id_i);
        end
        // a kill on the same owner beats the write, so the WB has no effect at all
        wb_eff = wb_acc && !clear_i && !kill_hit[wb_rd_i];
        case (wb_mode_i)
            2'b00:   wb_new = wb_wdata_i;
            2'b01:   wb_new = (regs_q[wb_rd_i] << DATA_WIDTH) | (wb_wdata_i & TAP_MASK);
            default: wb_new = regs_q[wb_rd_i];
        endcase
        for (int r = 0; r < NB_REGS; r++) begin
`ifdef FIR_XIFU_FWD_EN
            pend[r] = sb_q[r] && !(wb_eff && (wb_rd_i == RW'(r)));
`else
            pend[r] = sb_q[r];
`endif
        end
    end

    always_comb begin
        ready = !(id_rd_we_i && pend[id_rd_i]);
        for (int p = 0; p < NB_RPORTS; p++) begin
            if (id_rs_use_i[p] && pend[rs_idx[p]]) ready = 1'b0;
        end
        issue_acc = id_valid_i && ready && id_rd_we_i && !clear_i;
    end

    for (genvar p = 0; p < NB_RPORTS; p++) begin : g_rport
        assign rs_idx[p] = id_rs_i[p*RW +: RW];
`ifdef FIR_XIFU_FWD_EN
        assign id_rdata_o[p*32 +: 32] = (wb_eff && (rs_idx[p] == wb_rd_i)) ? wb_new : regs_q[rs_idx[p]];
`else
        assign id_rdata_o[p*32 +: 32] = regs_q[rs_idx[p]];
`endif
    end

    // issue-set is applied last so that, with bypass, it wins over a same-cycle release
    always_comb begin
        regs_d   = regs_q;
        sb_d     = sb_q;
        owner_d  = owner_q;
        wb_err_d = wb_valid_i && !wb_acc && !clear_i;
        if (clear_i) begin
            regs_d  = '0;
            sb_d    = '0;
            owner_d = '0;
        end else begin
            sb_d = sb_q & ~kill_hit;
            if (wb_eff) begin
                sb_d[wb_rd_i]   = 1'b0;
                regs_d[wb_rd_i] = wb_new;
            end
            if (issue_acc) begin
                sb_d[id_rd_i]    = 1'b1;
                owner_d[id_rd_i] = id_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q   <= '0;
            sb_q     <= '0;
            owner_q  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_q     <= sb_d;
            owner_q  <= owner_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign id_ready_o = ready;
    assign sb_o       = sb_q;
    assign busy_o     = |sb_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: doc/fir_xifu_regfile_sb.md
Name: fir_xifu_regfile_sb

Overview:
- Parametrised successor to the FIR XIFU control register file.
- Holds NB_REGS 32-bit packed-tap registers and provides NB_RPORTS combinational read ports to ID and one write port from WB.
- Adds a per-register scoreboard with owner instruction ID for RAW/WAW stall, commit-kill, and a sample shift-in write mode for delay lines of DATA_WIDTH-bit taps.
- Sits between ID and WB of the XIFU pipeline.

Parameters:
- NB_REGS, 4, number of 32-bit registers (>=2, power of two); RW = log2(NB_REGS).
- DATA_WIDTH, 8, tap width; legal values 8, 16, 32; TAPS_PER_WORD = 32/DATA_WIDTH.
- NB_RPORTS, 2, number of ID read ports.
- ID_WIDTH, 4, width of the CV-X-IF instruction ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- clear_i  in  1  synchronous clear of regs, scoreboard and owners
- id_valid_i  in  1  ID has an instruction requesting issue
- id_rs_i  in  NB_RPORTS*RW  source register indices
- id_rs_use_i  in  NB_RPORTS  per-port source-used flag
- id_rd_i  in  RW  destination index
- id_rd_we_i  in  1  instruction writes rd
- id_id_i  in  ID_WIDTH  instruction ID
- id_ready_o  out  1  no hazard; issue accepted when id_valid_i && id_ready_o
- id_rdata_o  out  NB_RPORTS*32  read data
- wb_valid_i  in  1  WB write request
- wb_rd_i  in  RW  WB destination
- wb_id_i  in  ID_WIDTH  WB instruction ID
- wb_mode_i  in  2  00 word write, 01 sample shift-in, 10 release only, 11 reserved (treated as release only)
- wb_wdata_i  in  32  write data
- kill_valid_i  in  1  commit kill
- kill_id_i  in  ID_WIDTH  killed instruction ID
- sb_o  out  NB_REGS  scoreboard, registered
- busy_o  out  1  OR of sb_o
- wb_err_o  out  1  registered one-cycle pulse on a rejected WB

Behaviour:
- Reset: regs, sb, owners = 0; sb_o = 0; busy_o = 0; wb_err_o = 0; id_ready_o = 1 (comb.); id_rdata_o = 0.
- Read: id_rdata_o[p] = regs_q[id_rs_i[p]], combinational. A write is visible the cycle after WB.
- Hazard: id_ready_o = 0 if any port p has id_rs_use_i[p] && sb_q[rs], or if id_rd_we_i && sb_q[rd]. id_ready_o is independent of id_valid_i.
- Issue accept with id_rd_we_i: next cycle sb[rd] = 1 and owner[rd] = id_id_i. Issue without rd_we changes no state.
- WB is accepted iff wb_valid_i && sb_q[wb_rd_i] && owner[wb_rd_i] == wb_id_i. On accept, sb is cleared and the register is updated by mode:
  - 00: reg <= wb_wdata_i.
  - 01: reg <= {reg[31-DATA_WIDTH:0], wb_wdata_i[DATA_WIDTH-1:0]}. For DATA_WIDTH = 32 this equals a word write.
  - 10/11: no data change.
- WB rejected (wb_valid_i with the accept condition false): no state change; wb_err_o = 1 the next cycle.
- Kill: if kill_valid_i, every register with sb set and owner == kill_id_i clears sb; data is unchanged.
- Priority per register, highest first: clear_i > kill > WB > issue-set.
  - Kill and WB on the same register and ID: kill wins, no write, wb_err_o stays 0.
  - Issue-set and release of the same register in one cycle cannot occur without forwarding, because ID stalls.
- clear_i: all state returns to reset values the next cycle; an issue accepted in the same cycle is dropped.
- Owners are only meaningful while sb is set.

Optional Feature:
- FIR_XIFU_FWD_EN defined: WB-to-ID bypass.
  - An accepted WB in this cycle makes the register count as not pending for the rs and rd checks.
  - id_rdata_o returns the post-mode new value when id_rs_i[p] == wb_rd_i, within the same cycle.
  - If an issue targets the same rd in that cycle, the set wins: sb = 1 and owner = id_id_i.
  - Kill and clear_i suppress the bypass.
- FIR_XIFU_FWD_EN undefined: no bypass; hazards use sb_q only; WB data is visible one cycle later.

Test Plan:
- Reset, then read r0..r3 -> all 0, id_ready_o = 1, sb_o = 0000, busy_o = 0.
- Issue rd = 2, id = 5. Next cycle, ID with rs0 = 2 used -> id_ready_o = 0. WB rd = 2, id = 5, mode 00, data 0xDEADBEEF -> one cycle later sb_o = 0000, id_rdata_o[0] = 0xDEADBEEF, id_ready_o = 1.
- DATA_WIDTH = 8, r1 = 0x11223344. Issue rd = 1, id = 3; WB mode 01, data 0x000000AB -> r1 = 0x223344AB. Repeat with data 0xCD -> 0x3344ABCD.
- Issue rd = 0, id = 7. WB rd = 0 with id = 6 -> r0 unchanged, sb_o[0] = 1, wb_err_o pulses 1 for one cycle. Then kill id = 7 -> sb_o = 0000, r0 unchanged.
- Same cycle: kill id = 4 and WB rd = 3, id = 4, data 0x55 on pending r3 -> sb cleared, r3 unchanged, wb_err_o = 0. clear_i asserted mid-operation with sb = 0110 -> next cycle all regs 0, sb_o = 0000.
- With FIR_XIFU_FWD_EN: r2 pending (id = 1); in one cycle WB rd = 2 data 0x12345678 and ID reads rs0 = 2 -> id_ready_o = 1 and id_rdata_o[0] = 0x12345678 in that same cycle. Without the macro -> id_ready_o = 0 that cycle.
